// File: rtl/trafficlight_pkg.sv
// Shared definitions for the traffic-light controller and its pedestrian front end.
// Counter widths are derived here so both blocks size their counters identically.
package trafficlight_pkg;

    typedef enum logic [1:0] {
        PR_IDLE    = 2'd0,
        PR_PENDING = 2'd1,
        PR_LOCKOUT = 2'd2
    } PedReqState;

    // Never returns 0, so a counter that only ever holds one value still gets a real bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stability counter for a raw mechanical input.
// The output changes only after the synchronized input differs from it for DEB_CYCLES cycles.
module debouncer
    import trafficlight_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);

    localparam int unsigned DW = cnt_width(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        // Any return to the current level restarts the stability count.
        if (sync2_q == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            stable_d = sync2_q;
            dcnt_d   = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            dcnt_q   <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/ped_request.sv
// Pedestrian request conditioner: debounced button press latches one request for the
// controller, and a post-service lockout keeps a stuck button from re-arming it at once.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   PR_IDLE    | no request; a debounced press edge latches one
//   PR_PENDING | request presented to the controller, waiting for served
//   PR_LOCKOUT | request served; button ignored for LOCK_CYCLES cycles
module ped_request
    import trafficlight_pkg::*;
#(
    parameter int unsigned FPGAFREQ      = 50_000_000,
    parameter int unsigned T_DEBOUNCE_MS = 20,
    parameter int unsigned T_LOCKOUT     = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic b_npeaton,
    input  logic served,
    output logic req,
    output logic sol_light,
    output logic busy
);

    localparam int unsigned DEB_CYCLES  = FPGAFREQ * T_DEBOUNCE_MS / 1000;
    localparam int unsigned LOCK_CYCLES = T_LOCKOUT * FPGAFREQ;
    localparam int unsigned LW          = cnt_width(LOCK_CYCLES);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LOCK_CYCLES - 1);

    logic          stable;
    logic          press;
    logic          stable_dly_q, stable_dly_d;
    PedReqState    state_q, state_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;

    debouncer #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .reset (reset),
        .din   (b_npeaton),
        .stable(stable)
    );

    // Button is active-low, so a press is the debounced 1 -> 0 edge.
    assign press = stable_dly_q & ~stable;

    always_comb begin
        stable_dly_d = stable;
        state_d      = state_q;
        lcnt_d       = lcnt_q;
        unique case (state_q)
            PR_IDLE: begin
                if (press) begin
                    state_d = PR_PENDING;
                end
            end
            PR_PENDING: begin
                if (served) begin
                    state_d = PR_LOCKOUT;
                    lcnt_d  = '0;
                end
            end
            PR_LOCKOUT: begin
                if (lcnt_q == LCNT_LAST) begin
                    state_d = PR_IDLE;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = PR_IDLE;
                lcnt_d  = '0;
            end
        endcase
        // Outputs registered alongside the state so they never glitch.
        req_d  = (state_d == PR_PENDING);
        busy_d = (state_d == PR_LOCKOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_dly_q <= 1'b1;
            state_q      <= PR_IDLE;
            lcnt_q       <= '0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            stable_dly_q <= stable_dly_d;
            state_q      <= state_d;
            lcnt_q       <= lcnt_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
        end
    end

    assign req       = req_q;
    assign sol_light = req_q;
    assign busy      = busy_q;

endmodule
